// File: rtl/ncc_stream_matcher_if.sv
// ncc_stream_matcher_if
//   Bundles the control, descriptor stream, window stream and result signals
//   of the NCC stream matcher.
//   master modport: the side that issues start, streams descriptor and window
//                   beats, and receives the search result.
//   slave modport : the matcher itself.
//   Signals:
//     start, num_windows          search request and window count
//     desc_valid/ready/data       descriptor beat handshake, lane 0 at LSBs
//     win_valid/ready/data        window beat handshake, same lane order
//     result_valid, found,        search result, held until the next accepted
//     best_index, best_num,       start or reset
//     best_wsos, desc_sos
interface ncc_stream_matcher_if #(
  parameter int PIX_W     = 9,
  parameter int LANES     = 4,
  parameter int PATCH_PIX = 256,
  parameter int IDX_W     = 13
);
  localparam int ACC_W  = 2 * PIX_W + $clog2(PATCH_PIX);
  localparam int DATA_W = LANES * PIX_W;

  logic              start;
  logic [IDX_W-1:0]  num_windows;
  logic              desc_valid;
  logic              desc_ready;
  logic [DATA_W-1:0] desc_data;
  logic              win_valid;
  logic              win_ready;
  logic [DATA_W-1:0] win_data;
  logic              result_valid;
  logic              found;
  logic [IDX_W-1:0]  best_index;
  logic [ACC_W-1:0]  best_num;
  logic [ACC_W-1:0]  best_wsos;
  logic [ACC_W-1:0]  desc_sos;

  modport master (
    output start, num_windows, desc_valid, desc_data, win_valid, win_data,
    input  desc_ready, win_ready, result_valid, found, best_index,
           best_num, best_wsos, desc_sos
  );

  modport slave (
    input  start, num_windows, desc_valid, desc_data, win_valid, win_data,
    output desc_ready, win_ready, result_valid, found, best_index,
           best_num, best_wsos, desc_sos
  );
endinterface

// File: rtl/ncc_stream_matcher.sv
// ncc_stream_matcher
//   Streams a reference descriptor patch into a local buffer, then streams a
//   series of candidate windows of the same size. For each window it forms the
//   signed dot product with the descriptor (num) and the window energy (wsos),
//   and keeps the window with the largest num^2/wsos among windows with
//   num > 0 and wsos > 0. The ratio comparison is done by cross-multiplying so
//   no divider is needed. Ties keep the earlier window.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  ncc_stream_matcher_if.slave (start/num_windows, descriptor and
//          window beat streams, registered result outputs)
module ncc_stream_matcher #(
  parameter int PIX_W     = 9,
  parameter int LANES     = 4,
  parameter int PATCH_PIX = 256,
  parameter int IDX_W     = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  ncc_stream_matcher_if.slave  bus
);

  localparam int BEATS  = PATCH_PIX / LANES;
  localparam int ACC_W  = 2 * PIX_W + $clog2(PATCH_PIX);
  localparam int DATA_W = LANES * PIX_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PROD_W = 3 * ACC_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_CMP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Sum over lanes of pix^2; each square is non-negative so the result is
  // returned as an unsigned accumulator increment.
  function automatic logic [ACC_W-1:0] beat_sos(input logic [DATA_W-1:0] pix);
    logic signed [ACC_W-1:0] p;
    logic signed [ACC_W-1:0] acc;
    acc = '0;
    for (int l = 0; l < LANES; l++) begin
      p   = ACC_W'($signed(pix[l*PIX_W +: PIX_W]));
      acc = acc + p * p;
    end
    return acc;
  endfunction

  // Signed sum over lanes of a*b.
  function automatic logic signed [ACC_W-1:0] beat_dot(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
    logic signed [ACC_W-1:0] pa;
    logic signed [ACC_W-1:0] pb;
    logic signed [ACC_W-1:0] acc;
    acc = '0;
    for (int l = 0; l < LANES; l++) begin
      pa  = ACC_W'($signed(a[l*PIX_W +: PIX_W]));
      pb  = ACC_W'($signed(b[l*PIX_W +: PIX_W]));
      acc = acc + pa * pb;
    end
    return acc;
  endfunction

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [IDX_W-1:0]        win_idx_q, win_idx_d;
  logic [IDX_W-1:0]        nwin_q, nwin_d;
  logic signed [ACC_W-1:0] num_q, num_d;
  logic [ACC_W-1:0]        wsos_q, wsos_d;
  logic [ACC_W-1:0]        desc_sos_q, desc_sos_d;
  logic                    found_q, found_d;
  logic [IDX_W-1:0]        best_index_q, best_index_d;
  logic [ACC_W-1:0]        best_num_q, best_num_d;
  logic [ACC_W-1:0]        best_wsos_q, best_wsos_d;
  logic                    result_valid_q, result_valid_d;
  logic                    desc_ready_q, desc_ready_d;
  logic                    win_ready_q, win_ready_d;

  // Descriptor storage, one entry per beat; contents are only read after a
  // full load, so it carries no reset.
  logic [DATA_W-1:0]       desc_buf_q [BEATS];
  logic                    buf_we_s;

  logic                    beat_last_s;
  logic [IDX_W-1:0]        win_idx_inc_s;
  logic                    qualify_s;
  logic                    better_s;
  logic [PROD_W-1:0]       num_u_s;
  logic [PROD_W-1:0]       best_num_u_s;
  logic [PROD_W-1:0]       lhs_s;
  logic [PROD_W-1:0]       rhs_s;

  assign beat_last_s   = (beat_q == BEAT_W'(BEATS - 1));
  assign win_idx_inc_s = win_idx_q + IDX_W'(1);

  // Candidate scoring: compare num^2/wsos against best_num^2/best_wsos by
  // cross-multiplication. Both nums are positive whenever the result is used,
  // so zero-extending them to the product width is exact.
  always_comb begin
    qualify_s    = ($signed(num_q) > $signed(ACC_W'(0))) && (wsos_q != '0);
    num_u_s      = PROD_W'($unsigned(num_q));
    best_num_u_s = PROD_W'(best_num_q);
    lhs_s        = num_u_s * num_u_s * PROD_W'(best_wsos_q);
    rhs_s        = best_num_u_s * best_num_u_s * PROD_W'(wsos_q);
    better_s     = (lhs_s > rhs_s);
  end

  // Next-state and datapath update for the search FSM.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    win_idx_d    = win_idx_q;
    nwin_d       = nwin_q;
    num_d        = num_q;
    wsos_d       = wsos_q;
    desc_sos_d   = desc_sos_q;
    found_d      = found_q;
    best_index_d = best_index_q;
    best_num_d   = best_num_q;
    best_wsos_d  = best_wsos_q;
    buf_we_s     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          nwin_d       = bus.num_windows;
          found_d      = 1'b0;
          best_index_d = '0;
          best_num_d   = '0;
          best_wsos_d  = '0;
          desc_sos_d   = '0;
          beat_d       = '0;
          win_idx_d    = '0;
          num_d        = '0;
          wsos_d       = '0;
          state_d      = ST_LOAD;
        end else begin
          state_d = state_q;
        end
      end

      ST_LOAD: begin
        if (bus.desc_valid) begin
          buf_we_s   = 1'b1;
          desc_sos_d = desc_sos_q + beat_sos(bus.desc_data);
          if (beat_last_s) begin
            beat_d  = '0;
            state_d = (nwin_q == '0) ? ST_DONE : ST_ACCUM;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_ACCUM: begin
        if (bus.win_valid) begin
          num_d  = num_q + beat_dot(bus.win_data, desc_buf_q[beat_q]);
          wsos_d = wsos_q + beat_sos(bus.win_data);
          if (beat_last_s) begin
            beat_d  = '0;
            state_d = ST_CMP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end

      ST_CMP: begin
        // Strict '>' means an equal score never displaces the earlier index.
        if (qualify_s && (!found_q || better_s)) begin
          found_d      = 1'b1;
          best_index_d = win_idx_q;
          best_num_d   = num_q;
          best_wsos_d  = wsos_q;
        end else begin
          found_d = found_q;
        end
        num_d     = '0;
        wsos_d    = '0;
        win_idx_d = win_idx_inc_s;
        state_d   = (win_idx_inc_s == nwin_q) ? ST_DONE : ST_ACCUM;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake and status outputs are registered from the next state so they
    // line up with the state register.
    desc_ready_d   = (state_d == ST_LOAD);
    win_ready_d    = (state_d == ST_ACCUM);
    result_valid_d = (state_d == ST_DONE);
  end

  // State, counters, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      beat_q         <= '0;
      win_idx_q      <= '0;
      nwin_q         <= '0;
      num_q          <= '0;
      wsos_q         <= '0;
      desc_sos_q     <= '0;
      found_q        <= 1'b0;
      best_index_q   <= '0;
      best_num_q     <= '0;
      best_wsos_q    <= '0;
      result_valid_q <= 1'b0;
      desc_ready_q   <= 1'b0;
      win_ready_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      win_idx_q      <= win_idx_d;
      nwin_q         <= nwin_d;
      num_q          <= num_d;
      wsos_q         <= wsos_d;
      desc_sos_q     <= desc_sos_d;
      found_q        <= found_d;
      best_index_q   <= best_index_d;
      best_num_q     <= best_num_d;
      best_wsos_q    <= best_wsos_d;
      result_valid_q <= result_valid_d;
      desc_ready_q   <= desc_ready_d;
      win_ready_q    <= win_ready_d;
    end
  end

  // Descriptor buffer write, one slot per accepted descriptor beat.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      desc_buf_q[beat_q] <= bus.desc_data;
    end
  end

  assign bus.desc_ready   = desc_ready_q;
  assign bus.win_ready    = win_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.found        = found_q;
  assign bus.best_index   = best_index_q;
  assign bus.best_num     = best_num_q;
  assign bus.best_wsos    = best_wsos_q;
  assign bus.desc_sos     = desc_sos_q;

endmodule

// File: doc/ncc_stream_matcher.md
NCC_STREAM_MATCHER -- requirements
Module: ncc_stream_matcher

Interface
REQ-001 SHALL have parameter PIX_W, default 9, signed pixel width.
REQ-002 SHALL have parameter LANES, default 4, pixels per beat; PATCH_PIX a multiple of LANES.
REQ-003 SHALL have parameter PATCH_PIX, default 256, pixels per patch; BEATS = PATCH_PIX/LANES.
REQ-004 SHALL have parameter IDX_W, default 13, window index width; ACC_W = 2*PIX_W+clog2(PATCH_PIX).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  pulse: begin a search.
REQ-009 num_windows  in  IDX_W  number of candidate windows, sampled on accepted start.
REQ-010 desc_valid / desc_ready  in / out  1  descriptor beat handshake.
REQ-011 desc_data  in  LANES*PIX_W  descriptor pixels; lane 0 at LSBs.
REQ-012 win_valid / win_ready  in / out  1  window beat handshake.
REQ-013 win_data  in  LANES*PIX_W  window pixels, same lane order.
REQ-014 result_valid  out  1  search complete, held high.
REQ-015 found  out  1  at least one qualifying window.
REQ-016 best_index  out  IDX_W  index of best window.
REQ-017 best_num  out  ACC_W  signed dot product of best window.
REQ-018 best_wsos  out  ACC_W  unsigned window sum of squares of best window.
REQ-019 desc_sos  out  ACC_W  unsigned descriptor sum of squares.

Function
REQ-020 States SHALL be IDLE, LOAD, ACCUM, CMP, DONE.
REQ-021 start SHALL be accepted only in IDLE or DONE; it is ignored elsewhere.
REQ-022 Accepted start SHALL clear found, best_*, desc_sos, beat counter, window index, and result_valid, then enter LOAD.
REQ-023 In LOAD, desc_ready SHALL be 1; each desc_valid&&desc_ready beat SHALL be stored at buffer slot beat and add the sum of lane squares to desc_sos.
REQ-024 After beat BEATS-1 is accepted, the FSM SHALL enter ACCUM, or DONE if the sampled num_windows is 0.
REQ-025 In ACCUM, win_ready SHALL be 1; each accepted beat SHALL add the sum over lanes of win*desc[slot beat] to num and win^2 to wsos. Arithmetic is signed and full-width ACC_W with no saturation.
REQ-026 Stalls (valid low) SHALL hold all state; a beat SHALL be counted only on valid&&ready.
REQ-027 After beat BEATS-1, ACCUM SHALL go to CMP for exactly one cycle with win_ready=0.
REQ-028 In CMP, a candidate SHALL qualify iff num>0 and wsos>0.
REQ-029 A qualifying candidate SHALL replace best if found==0, or if num^2*best_wsos > best_num^2*wsos, using unsigned products of width 3*ACC_W.
REQ-030 Ties SHALL keep the earlier index.
REQ-031 On replacement, best_index SHALL take the current window index, then found<=1.
REQ-032 After CMP, num and wsos SHALL clear and the window index SHALL increment.
REQ-033 After CMP, the FSM SHALL go to ACCUM, or to DONE if the incremented index equals num_windows.
REQ-034 In DONE, result_valid SHALL be 1 and the outputs SHALL hold until the next accepted start or reset.
REQ-035 Latency: result_valid SHALL rise exactly 1 cycle after the final CMP cycle.
REQ-036 A descriptor load SHALL take at least BEATS cycles; each window SHALL take at least BEATS+1 cycles.
REQ-037 desc_ready and win_ready SHALL be 0 in all states other than LOAD and ACCUM respectively.

Reset
REQ-038 rst SHALL force IDLE, clear all counters and accumulators, and drive every output to 0 (result_valid, found, best_*, desc_sos, desc_ready, win_ready).
REQ-039 rst asserted mid-LOAD or mid-ACCUM SHALL abandon the search with no result.
REQ-040 After reset release, a new start SHALL be required to begin a search.
REQ-041 The descriptor buffer SHALL need no reset.

Verification
REQ-042 Matched patch: defaults, desc lanes {-1,1,-1,1} for 64 beats, num_windows=1, identical window -> desc_sos=256, best_num=256, best_wsos=256, best_index=0, found=1.
REQ-043 Best of three: num_windows=3, windows = desc, -desc, 2*desc -> best_index=0 (tie with window 2 keeps earlier), best_num=256.
REQ-044 Negatives only: one window = -desc -> found=0, result_valid=1, best_index=0.
REQ-045 Zero windows: num_windows=0 -> result_valid 1 cycle after the 64th desc beat, found=0.
REQ-046 Backpressure and abort: random valid gaps give results identical to REQ-043; rst at beat 30 of window 1 -> all outputs 0, state IDLE, start ignored mid-search.
